// File: rtl/iic_slave_regs.sv
// I2C target with an 8-bit register window. SCL/SDA are oversampled on Clk;
// writes leave as one-cycle strobes, and reads are served from Rd_data with pointer auto-increment.
module iic_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR  = 7'b1110110,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       SCL,
  input  logic       SDA_in,
  output logic       SDA_oe,
  output logic [7:0] Reg_addr,
  output logic [7:0] Wr_data,
  output logic       Wr_strobe,
  input  logic [7:0] Rd_data,
  output logic       Busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   byte_full_q, byte_full_d;
  logic [7:0]             shift_q, shift_d;
  logic                   rw_q, rw_d;
  logic                   master_ack_q, master_ack_d;
  logic                   sda_oe_q, sda_oe_d;
  logic [7:0]             reg_addr_q, reg_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic                   wr_strobe_q, wr_strobe_d;
  logic                   busy_q, busy_d;

  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, bus_start, bus_stop;
  logic [7:0] rx_byte;
  logic [2:0] tx_idx;
  logic       rx_done;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  =  scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s &  scl_prev_q;
  // Start/stop need SCL high in both samples, so SDA edges during SCL low never qualify.
  assign bus_start = scl_s & scl_prev_q &  sda_prev_q & ~sda_s;
  assign bus_stop  = scl_s & scl_prev_q & ~sda_prev_q &  sda_s;
  assign rx_byte   = {shift_q[6:0], sda_s};
  assign tx_idx    = 3'd6 - bit_cnt_q;

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_full_d  = byte_full_q;
    shift_d      = shift_q;
    rw_d         = rw_q;
    master_ack_d = master_ack_q;
    sda_oe_d     = sda_oe_q;
    reg_addr_d   = reg_addr_q;
    wr_data_d    = wr_data_q;
    wr_strobe_d  = 1'b0;
    busy_d       = busy_q;
    rx_done      = 1'b0;

    if (wr_strobe_q) reg_addr_d = reg_addr_q + 8'd1;

    if (bus_stop) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (bus_start) begin
      state_d     = ADDR;
      sda_oe_d    = 1'b0;
      bit_cnt_d   = 3'd0;
      byte_full_d = 1'b0;
    end else begin
      if ((state_q inside {ADDR, REG, WDATA}) && scl_rise && !byte_full_q) begin
        shift_d   = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
        rx_done   = (bit_cnt_q == 3'd7);
      end

      case (state_q)
        IDLE: ;
        ADDR: begin
          if (rx_done) begin
            if (rx_byte[7:1] == SLAVE_ADDR) begin
              byte_full_d = 1'b1;
              rw_d        = rx_byte[0];
            end else begin
              state_d = IDLE;
            end
          end else if (scl_fall && byte_full_q) begin
            sda_oe_d    = 1'b1;
            busy_d      = 1'b1;
            byte_full_d = 1'b0;
            state_d     = ADDR_ACK;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 3'd0;
            if (rw_q) begin
              shift_d  = Rd_data;
              sda_oe_d = ~Rd_data[7];
              state_d  = RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = REG;
            end
          end
        end
        REG: begin
          if (rx_done) begin
            reg_addr_d  = rx_byte;
            byte_full_d = 1'b1;
          end else if (scl_fall && byte_full_q) begin
            sda_oe_d    = 1'b1;
            byte_full_d = 1'b0;
            state_d     = REG_ACK;
          end
        end
        REG_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = WDATA;
          end
        end
        WDATA: begin
          if (rx_done) begin
            wr_data_d   = rx_byte;
            byte_full_d = 1'b1;
          end else if (scl_fall && byte_full_q) begin
            wr_strobe_d = 1'b1;
            sda_oe_d    = 1'b1;
            byte_full_d = 1'b0;
            state_d     = WDATA_ACK;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              state_d  = RDATA_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              sda_oe_d  = ~shift_q[tx_idx];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            master_ack_d = ~sda_s;
            reg_addr_d   = reg_addr_q + 8'd1;
          end else if (scl_fall) begin
            if (master_ack_q) begin
              shift_d   = Rd_data;
              sda_oe_d  = ~Rd_data[7];
              bit_cnt_d = 3'd0;
              state_d   = RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      // NOTE: synchronisers reset to 1 so leaving reset looks like an idle bus, not a START.
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      scl_prev_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      byte_full_q  <= 1'b0;
      shift_q      <= 8'd0;
      rw_q         <= 1'b0;
      master_ack_q <= 1'b0;
      sda_oe_q     <= 1'b0;
      reg_addr_q   <= 8'd0;
      wr_data_q    <= 8'd0;
      wr_strobe_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      scl_sync_q   <= {scl_sync_q[SYNC_STAGES-2:0], SCL};
      sda_sync_q   <= {sda_sync_q[SYNC_STAGES-2:0], SDA_in};
      scl_prev_q   <= scl_s;
      sda_prev_q   <= sda_s;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_full_q  <= byte_full_d;
      shift_q      <= shift_d;
      rw_q         <= rw_d;
      master_ack_q <= master_ack_d;
      sda_oe_q     <= sda_oe_d;
      reg_addr_q   <= reg_addr_d;
      wr_data_q    <= wr_data_d;
      wr_strobe_q  <= wr_strobe_d;
      busy_q       <= busy_d;
    end
  end

  assign SDA_oe    = sda_oe_q;
  assign Reg_addr  = reg_addr_q;
  assign Wr_data   = wr_data_q;
  assign Wr_strobe = wr_strobe_q;
  assign Busy      = busy_q;

endmodule

// File: doc/iic_slave_regs.md
Name: iic_slave_regs

Overview:
- I2C target (responder) exposing an 8-bit register window to an external I2C master, such as a host/debug controller or a second board.
- It is the other end of the single-master write sequences the team's I2C initiators generate: START, 7-bit address + R/W, register pointer, data bytes, STOP.
- It oversamples SCL/SDA on the system clock, ACKs its address, and emits one-cycle register write strobes.
- It serves reads from an external register file via Reg_addr/Rd_data, with pointer auto-increment.

Parameters:
- SLAVE_ADDR, 7'b1110110, 7-bit target address matched against the first byte after START.
- SYNC_STAGES, 2, flip-flop stages on SCL and SDA before edge detection (minimum 2).

Ports:
- Clk  input  1  system clock; must be at least 10x the SCL rate.
- Reset_n  input  1  synchronous active-low reset.
- SCL  input  1  I2C clock from the bus (already buffered).
- SDA_in  input  1  I2C data as seen on the bus.
- SDA_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- Reg_addr  output  8  current register pointer.
- Wr_data  output  8  last received data byte.
- Wr_strobe  output  1  one-cycle pulse; Wr_data is to be written at Reg_addr.
- Rd_data  input  8  contents of the register at Reg_addr, combinational from the user.
- Busy  output  1  high from an address-matched START until STOP.

Behaviour:
- Reset is Reset_n, synchronous, active-low; clock is Clk. All state is updated on posedge Clk only.
- Reset values: SDA_oe=0, Reg_addr=0, Wr_data=0, Wr_strobe=0, Busy=0, state=IDLE. Sync flops reset to 1 (bus idle).
- Synchronised scl_s/sda_s are edge-detected against their previous values.
- START = sda_s falls while scl_s=1. STOP = sda_s rises while scl_s=1.
- Bits are sampled on scl_s rise, MSB first.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- Bit counter is 0..7, cleared on START and on entry to each byte state.
- IDLE: START -> ADDR.
- ADDR: after the 8th rise, if byte[7:1]==SLAVE_ADDR, assert SDA_oe at the next scl fall and go to ADDR_ACK; Busy=1 from that fall. On mismatch -> IDLE and SDA_oe stays 0.
- ADDR_ACK: release SDA_oe at the following scl fall.
  - R/W=0 -> REG.
  - R/W=1 -> RDATA, loading the shift register with Rd_data in the same cycle and driving bit7 immediately (SDA_oe = ~bit).
- REG: after the 8th rise, load Reg_addr with the byte. ACK at the next fall -> REG_ACK, released on the following fall -> WDATA.
- WDATA: after the 8th rise, Wr_data=byte. At the next scl fall, Wr_strobe=1 for exactly one Clk and SDA_oe=1 (ACK) -> WDATA_ACK.
  - Reg_addr increments (mod 256, 8'hFF -> 8'h00) the cycle after the strobe.
- WDATA_ACK: release at the next fall -> WDATA (multi-byte burst).
- RDATA: shift the next bit onto SDA at each scl fall. After the 8th bit's fall, release SDA_oe -> RDATA_ACK.
- RDATA_ACK: sample the master ACK on the 9th rise; Reg_addr increments at that rise.
  - ACK (0): reload from Rd_data at the next fall, drive bit7 -> RDATA.
  - NACK (1): SDA_oe=0 -> IDLE; Busy stays 1 until STOP.
- STOP in any state: -> IDLE, SDA_oe=0, Busy=0 in the same cycle. Any partial byte is discarded with no strobe.
- Repeated START in any state: -> ADDR, SDA_oe=0, bit counter cleared, Reg_addr preserved (supports write-pointer-then-read).
- Reset mid-transfer: immediate return to reset values; the bus is released within one Clk.
- SDA changes while SCL is low are never treated as START/STOP. START/STOP detection takes priority over bit sampling in the same cycle.

Test Plan:
- Write 0x76<<1|0, reg 0x49, data 0xC0, STOP -> three ACKs (SDA low during 9th clocks); one Wr_strobe with Reg_addr=0x49, Wr_data=0xC0; Reg_addr=0x4A afterwards; Busy drops at STOP.
- Burst write: reg 0xFE, data 0x11, 0x22, 0x33 -> strobes at Reg_addr 0xFE, 0xFF, 0x00 with data 0x11, 0x22, 0x33 in order.
- Address 0x50 write -> SDA_oe never asserts, no strobes, Busy stays 0; the following transaction to 0x76 is ACKed normally.
- Write pointer 0x21, repeated START, read with Rd_data=0x09 then 0xA5, master ACK then NACK -> bus carries 0x09 then 0xA5; Reg_addr ends at 0x23; SDA released after NACK.
- STOP injected after 4 data bits -> no Wr_strobe, state IDLE, SDA_oe=0; the next full write succeeds.
- Reset_n low during REG_ACK with SDA_oe=1 -> SDA_oe=0 and Reg_addr=0 on the next Clk edge.
